// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: default depth, pointer width and entry layout.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH = 8;
    localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch queue register file: paired write at idx/idx+1, paired read at idx/idx+1, cleared on reset.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  fq_entry_t                wr_data,
    input  fq_entry_t                wr_data2,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output fq_entry_t                rd_data,
    output fq_entry_t                rd_data2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_idx2;
    logic [PTR_W-1:0] rd_idx2;

    // Index arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        wr_idx2 = wr_idx + PTR_W'(1);
        rd_idx2 = rd_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx]  <= wr_data;
            mem[wr_idx2] <= wr_data2;
        end
    end

    always_comb begin
        rd_data  = mem[rd_idx];
        rd_data2 = mem[rd_idx2];
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode; define FETCH_QUEUE_PERF_EN to
// enable the fetch-stall cycle counter on fq_stall_cnt (otherwise it reads 0).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrf,
    input  logic [31:0] instrf2,
    input  logic [31:0] pcf,
    input  logic        fvalid,
    input  logic        flushd,
    input  logic [1:0]  issued,
    output logic [31:0] instrd,
    output logic [31:0] instrd2,
    output logic [31:0] pcd,
    output logic [31:0] pcd2,
    output logic        validd,
    output logic        validd2,
    output logic        stallf,
    output logic [31:0] fq_stall_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head, head_nx;
    logic [PTR_W-1:0] tail, tail_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [CNT_W-1:0] issued_ext, pop_n;
    logic             push;
    fq_entry_t        wr_data, wr_data2;
    fq_entry_t        rd_data, rd_data2;

    // Stall depends only on registered count, so there is no input-to-stallf path.
    always_comb begin
        stallf     = (count >= CNT_W'(DEPTH - 1));
        push       = fvalid & ~stallf & ~flushd;
        issued_ext = CNT_W'(issued);
        pop_n      = (issued_ext > count) ? count : issued_ext;
    end

    always_comb begin
        head_nx  = head;
        tail_nx  = tail;
        count_nx = count;
        if (flushd) begin
            head_nx  = '0;
            tail_nx  = '0;
            count_nx = '0;
        end else begin
            head_nx  = head + PTR_W'(pop_n);
            tail_nx  = push ? tail + PTR_W'(2) : tail;
            count_nx = count + (push ? CNT_W'(2) : CNT_W'(0)) - pop_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nx;
            tail  <= tail_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        wr_data  = '{pc: pcf,          instr: instrf};
        wr_data2 = '{pc: pcf + 32'd4, instr: instrf2};
    end

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push),
        .wr_idx   (tail),
        .wr_data  (wr_data),
        .wr_data2 (wr_data2),
        .rd_idx   (head),
        .rd_data  (rd_data),
        .rd_data2 (rd_data2)
    );

    always_comb begin
        instrd  = rd_data.instr;
        pcd     = rd_data.pc;
        instrd2 = rd_data2.instr;
        pcd2    = rd_data2.pc;
        validd  = (count != '0);
        validd2 = (count >= CNT_W'(2));
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stallf && fvalid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign fq_stall_cnt = stall_cnt;
`else
    assign fq_stall_cnt = '0;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of instruction entries; power of two, >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 instrf  input  32  fetched instruction at pcf.
REQ-005 instrf2  input  32  fetched instruction at pcf+4.
REQ-006 pcf  input  32  fetch PC of instrf.
REQ-007 fvalid  input  1  fetch pair valid this cycle.
REQ-008 flushd  input  1  decode redirect (branch/jump taken); discard all queued and incoming instructions.
REQ-009 issued  input  2  entries consumed by decode this cycle (0, 1 or 2).
REQ-010 instrd, instrd2  output  32 each  head entry and head+1 entry instructions.
REQ-011 pcd, pcd2  output  32 each  PCs of head and head+1 entries.
REQ-012 validd, validd2  output  1 each  head / head+1 entry holds a real instruction.
REQ-013 stallf  output  1  queue cannot accept a pair; drives fetch stall.
REQ-014 fq_stall_cnt  output  32  stall-cycle counter (see Configuration).

Function
REQ-015 Queue SHALL be a circular FIFO of DEPTH entries {pc[31:0], instr[31:0]} with head pointer, tail pointer (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
REQ-016 push = fvalid & ~stallf & ~flushd; on push, write {pcf, instrf} at tail and {pcf+4, instrf2} at tail+1; tail += 2.
REQ-017 stallf SHALL be 1 when count > DEPTH-2 (registered-state Moore decode, no combinational path from inputs).
REQ-018 pop = min(issued, count); head += pop; issued exceeding count is clipped, never underflows.
REQ-019 Same-cycle push and pop: count_next = count + 2*push - pop; both occur in that edge.
REQ-020 Outputs SHALL read storage combinationally at head and head+1; validd = (count >= 1), validd2 = (count >= 2); instrd/pcd are don't-care when invalid but SHALL equal 0 after reset.
REQ-021 Pushed pair SHALL appear at outputs no earlier than the cycle after the push edge (1-cycle latency, no bypass).
REQ-022 flushd SHALL override push and pop: head, tail, count <- 0 at the edge; validd, validd2 = 0 next cycle.
REQ-023 Pointer wrap: a pair written at tail = DEPTH-1 places second entry at index 0.
REQ-024 Full: count = DEPTH and count = DEPTH-1 both assert stallf; fvalid ignored while stallf = 1.

Reset
REQ-025 On reset low: head, tail, count = 0; validd, validd2 = 0; stallf = 0; storage cleared to 0; fq_stall_cnt = 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries; first edge after release behaves as empty queue.

Configuration
REQ-027 Macro FETCH_QUEUE_PERF_EN defined: fq_stall_cnt increments by 1 each cycle with stallf = 1 & fvalid = 1, saturating at 32'hFFFFFFFF, cleared only by reset.
REQ-028 Macro undefined: no counter register; fq_stall_cnt tied to 0.

Structure
REQ-029 Package fetch_queue_pkg SHALL hold DEPTH default, pointer width, and the entry type {pc, instr}.
REQ-030 Sub-module fq_storage SHALL implement the DEPTH-entry register file: two write ports (tail, tail+1), two read ports (head, head+1), async-reset to 0.

Verification
REQ-031 Reset, then fvalid=1, pcf=0x100, instrf=0xAAAA0001, instrf2=0xAAAA0002, issued=0 -> next cycle validd=validd2=1, pcd=0x100, pcd2=0x104, instrd=0xAAAA0001.
REQ-032 Push 4 pairs with issued=0 (DEPTH=8) -> after 3rd push count=6, stallf=0; after 4th count=8, stallf=1; 5th pair ignored, count stays 8.
REQ-033 count=3, same cycle push + issued=2 -> count=3; head advanced by 2; new pair at former tail.
REQ-034 count=1, issued=2 -> pop clipped to 1, count=0, validd=0, no pointer underflow.
REQ-035 count=6, flushd=1 with fvalid=1 -> next cycle count=0, validd=0, stallf=0; incoming pair not stored.
REQ-036 PERF_EN: hold queue full, fvalid=1 for 5 cycles -> fq_stall_cnt=5; without macro -> fq_stall_cnt=0.
